// File: rtl/alu_control_exec.sv
// ALU control + execute unit: decodes {ALUOp, funct}, runs the op (iterative
// shift-add for MULT) and returns a registered result over valid/ready handshakes.
module alu_control_exec #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             ALUOp,
    input  logic [5:0]             ALUFunction,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic [DATA_WIDTH-1:0]  operand_a,
    input  logic [DATA_WIDTH-1:0]  operand_b,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [3:0]             ALUOperation,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   zero,
    output logic                   overflow,
    output logic                   illegal,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int HALF = DATA_WIDTH / 2;
    localparam int MSB  = DATA_WIDTH - 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NOR  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_LUI  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_ILL  = 4'b1001;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              aluOp_q;
    logic [DATA_WIDTH-1:0]   result_q, opA_q, opB_q, acc_q;
    logic                    zero_q, overflow_q, illegal_q;
    logic [SHAMT_WIDTH-1:0]  cnt_q;

    logic [3:0]              decOp;
    logic                    decIllegal;
    logic [DATA_WIDTH-1:0]   sum, diff, execResult, partial, accNext;
    logic                    execOverflow, lastIter;

    always_comb begin
        decOp = OP_ILL;
        casez ({ALUOp, ALUFunction})
            9'b111_100100: decOp = OP_AND;
            9'b111_100101: decOp = OP_OR;
            9'b111_100111: decOp = OP_NOR;
            9'b111_100000: decOp = OP_ADD;
            9'b111_100010: decOp = OP_SUB;
            9'b111_000000: decOp = OP_SLL;
            9'b111_000010: decOp = OP_SRL;
            9'b111_011000: decOp = OP_MULT;
            9'b100_??????: decOp = OP_ADD;
            9'b101_??????: decOp = OP_OR;
            9'b110_??????: decOp = OP_LUI;
            default:       decOp = OP_ILL;
        endcase
    end

    assign decIllegal = (decOp == OP_ILL);
    assign sum        = operand_a + operand_b;
    assign diff       = operand_a - operand_b;

    // Single-cycle ops are evaluated straight off the inputs in the accept cycle.
    always_comb begin
        execResult   = '0;
        execOverflow = 1'b0;
        case (decOp)
            OP_AND: execResult = operand_a & operand_b;
            OP_OR:  execResult = operand_a | operand_b;
            OP_NOR: execResult = ~(operand_a | operand_b);
            OP_ADD: begin
                execResult   = sum;
                execOverflow = (operand_a[MSB] == operand_b[MSB]) && (sum[MSB] != operand_a[MSB]);
            end
            OP_SUB: begin
                execResult   = diff;
                execOverflow = (operand_a[MSB] != operand_b[MSB]) && (diff[MSB] != operand_a[MSB]);
            end
            OP_SLL: execResult = operand_b << shamt;
            OP_SRL: execResult = operand_b >> shamt;
            OP_LUI: execResult = {operand_b[HALF-1:0], {HALF{1'b0}}};
            default: execResult = '0;
        endcase
    end

    assign partial  = opB_q[cnt_q] ? (opA_q << cnt_q) : '0;
    assign accNext  = acc_q + partial;
    assign lastIter = (cnt_q == SHAMT_WIDTH'(DATA_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = (decOp == OP_MULT) ? MUL : DONE;
            MUL:  if (lastIter) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aluOp_q    <= OP_ILL;
            result_q   <= '0;
            zero_q     <= 1'b1;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
            opA_q      <= '0;
            opB_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    aluOp_q <= decOp;
                    opA_q   <= operand_a;
                    opB_q   <= operand_b;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    if (decOp != OP_MULT) begin
                        result_q   <= execResult;
                        zero_q     <= (execResult == '0);
                        overflow_q <= execOverflow;
                        illegal_q  <= decIllegal;
                    end
                end
                // One multiplier bit per cycle; the final partial sum is the result.
                MUL: begin
                    acc_q <= accNext;
                    cnt_q <= cnt_q + SHAMT_WIDTH'(1);
                    if (lastIter) begin
                        result_q   <= accNext;
                        zero_q     <= (accNext == '0);
                        overflow_q <= 1'b0;
                        illegal_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready     = (state_q == IDLE);
        out_valid    = (state_q == DONE);
        busy         = (state_q != IDLE);
        ALUOperation = aluOp_q;
        result       = result_q;
        zero         = zero_q;
        overflow     = overflow_q;
        illegal      = illegal_q;
    end

endmodule

// File: tb/tb_alu_control_exec.sv
// Randomized and directed bench for alu_control_exec at DATA_WIDTH 32 and 16,
// checked against a plain-arithmetic reference model.
module tb_alu_control_exec;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, inValid, outReady, useNarrow;
    logic [2:0]  aluOp;
    logic [5:0]  aluFunct;
    logic [4:0]  shamtIn;
    logic [31:0] opA, opB;

    logic        ready32, zero32, ovf32, ill32, valid32, busy32;
    logic [3:0]  code32;
    logic [31:0] res32;
    logic        ready16, zero16, ovf16, ill16, valid16, busy16;
    logic [3:0]  code16;
    logic [15:0] res16;

    logic        inValid32, inValid16;
    assign inValid32 = inValid & ~useNarrow;
    assign inValid16 = inValid & useNarrow;

    alu_control_exec #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut32 (
        .clk(clk), .reset(reset), .ALUOp(aluOp), .ALUFunction(aluFunct),
        .shamt(shamtIn), .operand_a(opA), .operand_b(opB), .in_valid(inValid32),
        .in_ready(ready32), .ALUOperation(code32), .result(res32), .zero(zero32),
        .overflow(ovf32), .illegal(ill32), .out_valid(valid32), .out_ready(outReady),
        .busy(busy32));

    alu_control_exec #(.DATA_WIDTH(16), .SHAMT_WIDTH(4)) dut16 (
        .clk(clk), .reset(reset), .ALUOp(aluOp), .ALUFunction(aluFunct),
        .shamt(shamtIn[3:0]), .operand_a(opA[15:0]), .operand_b(opB[15:0]), .in_valid(inValid16),
        .in_ready(ready16), .ALUOperation(code16), .result(res16), .zero(zero16),
        .overflow(ovf16), .illegal(ill16), .out_valid(valid16), .out_ready(outReady),
        .busy(busy16));

    logic        obsReady, obsValid, obsBusy, obsZero, obsOvf, obsIll;
    logic [3:0]  obsCode;
    logic [63:0] obsResult;
    assign obsReady  = useNarrow ? ready16 : ready32;
    assign obsValid  = useNarrow ? valid16 : valid32;
    assign obsBusy   = useNarrow ? busy16  : busy32;
    assign obsZero   = useNarrow ? zero16  : zero32;
    assign obsOvf    = useNarrow ? ovf16   : ovf32;
    assign obsIll    = useNarrow ? ill16   : ill32;
    assign obsCode   = useNarrow ? code16  : code32;
    assign obsResult = useNarrow ? {48'b0, res16} : {32'b0, res32};

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic longint toSigned(input longint unsigned v, input int w);
        if (((v >> (w - 1)) & 64'd1) != 0) return longint'(v) - (longint'(1) << w);
        return longint'(v);
    endfunction

    // Reference: table lookup for the code, then the operation as plain integer arithmetic.
    function automatic void refModel(input int w, input logic [2:0] op, input logic [5:0] fn,
                                     input int sh, input longint unsigned a, input longint unsigned b,
                                     output logic [3:0] code, output longint unsigned res,
                                     output logic ovf, output logic ill);
        longint unsigned mask = (longint'(1) << w) - 1;
        longint maxS = (longint'(1) << (w - 1)) - 1;
        longint minS = -(longint'(1) << (w - 1));
        longint s;
        code = 4'd9;
        if (op == 3'b111) begin
            if      (fn == 6'b100100) code = 4'd0;
            else if (fn == 6'b100101) code = 4'd1;
            else if (fn == 6'b100111) code = 4'd2;
            else if (fn == 6'b100000) code = 4'd3;
            else if (fn == 6'b100010) code = 4'd4;
            else if (fn == 6'b000000) code = 4'd6;
            else if (fn == 6'b000010) code = 4'd7;
            else if (fn == 6'b011000) code = 4'd8;
        end else if (op == 3'b100) code = 4'd3;
        else if (op == 3'b101) code = 4'd1;
        else if (op == 3'b110) code = 4'd5;
        ill = (code == 4'd9);
        ovf = 1'b0;
        res = 0;
        case (code)
            4'd0: res = a & b;
            4'd1: res = a | b;
            4'd2: res = ~(a | b) & mask;
            4'd3: begin
                s = toSigned(a, w) + toSigned(b, w);
                res = (a + b) & mask;
                ovf = (s > maxS) || (s < minS);
            end
            4'd4: begin
                s = toSigned(a, w) - toSigned(b, w);
                res = (a - b) & mask;
                ovf = (s > maxS) || (s < minS);
            end
            4'd5: res = (b % (longint'(1) << (w / 2))) * (longint'(1) << (w / 2));
            4'd6: res = (b << sh) & mask;
            4'd7: res = b >> sh;
            4'd8: res = (a * b) & mask;
            default: res = 0;
        endcase
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [5:0] fn, input int sh,
                                 input longint unsigned aIn, input longint unsigned bIn,
                                 input bit narrow, input int hold);
        int w = narrow ? 16 : 32;
        longint unsigned mask = (longint'(1) << w) - 1;
        longint unsigned a = aIn & mask;
        longint unsigned b = bIn & mask;
        logic [3:0] expCode;
        longint unsigned expRes;
        logic expOvf, expIll;
        int expLat, lat, tries;
        bit quietOk, stableOk;

        useNarrow = narrow;
        refModel(w, op, fn, sh, a, b, expCode, expRes, expOvf, expIll);
        expLat = (expCode == 4'd8) ? w + 1 : 1;

        tries = 0;
        while (!obsReady && tries < 10) begin
            @(negedge clk);
            tries++;
        end
        checkOutput("in_ready_before_accept", obsReady, 1);

        aluOp = op; aluFunct = fn; shamtIn = 5'(sh);
        opA = a[31:0]; opB = b[31:0]; inValid = 1'b1; outReady = 1'b0;
        @(posedge clk);

        lat = 0;
        quietOk = 1'b1;
        for (int k = 1; k <= w + 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                inValid = 1'b0;
                opA = $urandom; opB = $urandom; shamtIn = 5'($urandom);
                aluOp = 3'($urandom); aluFunct = 6'($urandom);
            end
            if (obsValid) begin
                lat = k;
                break;
            end
            if (obsReady || !obsBusy) quietOk = 1'b0;
        end
        checkOutput("out_valid_latency", 64'(lat), 64'(expLat));
        if (expLat > 1) checkOutput("busy_not_ready_during_mult", {63'b0, quietOk}, 1);
        checkOutput("ALUOperation", {60'b0, obsCode}, {60'b0, expCode});
        checkOutput("result", obsResult, expRes);
        checkOutput("zero", {63'b0, obsZero}, {63'b0, expRes == 0});
        checkOutput("overflow", {63'b0, obsOvf}, {63'b0, expOvf});
        checkOutput("illegal", {63'b0, obsIll}, {63'b0, expIll});

        stableOk = 1'b1;
        for (int k = 0; k < hold; k++) begin
            inValid = 1'b1;
            aluOp = 3'b111; aluFunct = 6'b100000;
            opA = $urandom; opB = $urandom;
            @(negedge clk);
            if (!obsValid || obsReady || obsResult != expRes || obsCode != expCode ||
                obsZero != (expRes == 0) || obsOvf != expOvf || obsIll != expIll)
                stableOk = 1'b0;
        end
        if (hold > 0) checkOutput("stable_under_backpressure", {63'b0, stableOk}, 1);

        inValid = 1'b0;
        outReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("out_valid_after_handshake", {63'b0, obsValid}, 0);
        checkOutput("in_ready_after_handshake", {63'b0, obsReady}, 1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_out_valid"}, {63'b0, obsValid}, 0);
        checkOutput({tag, "_result"}, obsResult, 0);
        checkOutput({tag, "_zero"}, {63'b0, obsZero}, 1);
        checkOutput({tag, "_overflow"}, {63'b0, obsOvf}, 0);
        checkOutput({tag, "_illegal"}, {63'b0, obsIll}, 0);
        checkOutput({tag, "_ALUOperation"}, {60'b0, obsCode}, 64'h9);
        checkOutput({tag, "_busy"}, {63'b0, obsBusy}, 0);
        checkOutput({tag, "_in_ready"}, {63'b0, obsReady}, 1);
    endtask

    // Abort a MULT mid-iteration with reset while a new request is also presented.
    task automatic resetDuringMult();
        bit sawValid = 1'b0;
        useNarrow = 1'b0;
        aluOp = 3'b111; aluFunct = 6'b011000; opA = 32'h1234_5678; opB = 32'hFFFF_FFFF;
        inValid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            inValid = 1'b0;
        end
        reset = 1'b1;
        inValid = 1'b1;
        aluOp = 3'b111; aluFunct = 6'b100000; opA = 32'd7; opB = 32'd9;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        inValid = 1'b0;
        checkResetState("mult_abort");
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (obsValid) sawValid = 1'b1;
        end
        checkOutput("no_stale_out_valid", {63'b0, sawValid}, 0);
        applyStimulus(3'b111, 6'b100000, 0, 2, 3, 1'b0, 0);
    endtask

    logic [8:0] selTab [11] = '{9'b111_100100, 9'b111_100101, 9'b111_100111, 9'b111_100000,
                                9'b111_100010, 9'b111_000000, 9'b111_000010, 9'b111_011000,
                                9'b100_010101, 9'b101_111000, 9'b110_000001};

    initial begin
        reset = 1'b1; inValid = 1'b0; outReady = 1'b0; useNarrow = 1'b0;
        aluOp = '0; aluFunct = '0; shamtIn = '0; opA = '0; opB = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkResetState("reset32");
        useNarrow = 1'b1;
        checkResetState("reset16");

        for (int i = 0; i < 11; i++)
            applyStimulus(selTab[i][8:6], selTab[i][5:0], 3, 32'h0F0F_1234, 32'h00FF_0006, 1'b0, 0);
        applyStimulus(3'b111, 6'b101010, 0, 32'h1111_1111, 32'h2222_2222, 1'b0, 0);
        applyStimulus(3'b000, 6'b000000, 0, 32'h1111_1111, 32'h2222_2222, 1'b0, 0);

        applyStimulus(3'b111, 6'b100000, 0, 32'h7FFF_FFFF, 32'h1, 1'b0, 0);
        applyStimulus(3'b111, 6'b100010, 0, 5, 5, 1'b0, 0);
        applyStimulus(3'b110, 6'b000000, 0, 0, 32'h1234, 1'b0, 0);
        applyStimulus(3'b111, 6'b000000, 31, 0, 1, 1'b0, 0);
        applyStimulus(3'b111, 6'b011000, 0, 32'h0001_0003, 32'h5, 1'b0, 0);
        applyStimulus(3'b111, 6'b100010, 0, 32'h8000_0000, 32'h1, 1'b0, 10);

        resetDuringMult();

        applyStimulus(3'b110, 6'b000000, 0, 0, 16'h00AB, 1'b1, 0);
        applyStimulus(3'b111, 6'b011000, 0, 16'h00FF, 16'h0101, 1'b1, 3);
        applyStimulus(3'b111, 6'b000010, 15, 0, 16'h8000, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            logic [8:0] sel;
            int pick = $urandom_range(0, 12);
            bit narrow = 1'($urandom_range(0, 1));
            sel = (pick < 11) ? selTab[pick] : 9'($urandom);
            if (sel[8:6] != 3'b111 && pick < 11) sel[5:0] = 6'($urandom);
            applyStimulus(sel[8:6], sel[5:0], narrow ? $urandom_range(0, 15) : $urandom_range(0, 31),
                          64'($urandom), 64'($urandom), narrow, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_control_exec.md
Name: alu_control_exec

Overview:
- Parametrised successor to the combinational ALU decoder.
- Decodes ALUOp/function into an operation code, executes the operation on DATA_WIDTH operands, and returns a registered result through valid/ready handshakes.
- Adds SUB, SLL, SRL and an iterative multi-cycle MULT (low word), plus zero, overflow and illegal-op flags.
- Sits between the control/ID stage and the writeback mux in the multi-cycle datapath.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and >= 8.
- SHAMT_WIDTH, 5, shift-amount width; must equal clog2(DATA_WIDTH).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- ALUOp  input  3  operation class from control unit
- ALUFunction  input  6  instruction funct field
- shamt  input  SHAMT_WIDTH  shift amount for SLL/SRL
- operand_a  input  DATA_WIDTH  rs value
- operand_b  input  DATA_WIDTH  rt value or extended immediate
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request
- ALUOperation  output  4  decoded code of the accepted op, registered
- result  output  DATA_WIDTH  registered result
- zero  output  1  result == 0
- overflow  output  1  signed overflow (ADD/ADDI/SUB only)
- illegal  output  1  undecodable selector
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- busy  output  1  state != IDLE

Behaviour:
- Selector = {ALUOp, ALUFunction}. Decode (casex, first match wins):
  - 111_100100 AND = 0000
  - 111_100101 OR = 0001
  - 111_100111 NOR = 0010
  - 111_100000 ADD = 0011
  - 111_100010 SUB = 0100
  - 111_000000 SLL = 0110
  - 111_000010 SRL = 0111
  - 111_011000 MULT = 1000
  - 100_xxxxxx ADDI = 0011
  - 101_xxxxxx ORI = 0001
  - 110_xxxxxx LUI = 0101
  - anything else = 1001, illegal=1
- Arithmetic, all modulo 2^DATA_WIDTH:
  - ADD = a+b; SUB = a-b.
  - overflow = (sign a == sign b') && (sign result != sign a), where b' is b for ADD and ~b for SUB.
  - SLL = b<<shamt; SRL = b>>shamt, logical.
  - LUI = b[DATA_WIDTH/2-1:0] concatenated with DATA_WIDTH/2 zeros.
  - MULT = low DATA_WIDTH bits of unsigned a*b.
  - Illegal op: result = 0, zero = 1.
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready=1. On in_valid, latch operands and ALUOperation.
    - Non-MULT: compute and register result/flags, go to DONE. out_valid rises the cycle after acceptance (latency 1).
    - MULT: clear accumulator and counter, go to MUL.
  - MUL: shift-add, one multiplier bit per cycle. Counter runs 0..DATA_WIDTH-1. On the last iteration, register result/flags and go to DONE. out_valid rises DATA_WIDTH+1 cycles after acceptance.
  - DONE: out_valid=1; result, flags and ALUOperation held stable. On out_ready, go to IDLE. in_ready=0 in DONE and MUL, so there is no back-to-back overlap. The next request can be accepted the cycle after the output handshake.
- Operand inputs are ignored outside the accept cycle. Later changes to inputs do not affect an in-flight op.
- overflow=0 and illegal=0 for every op they do not apply to.
- Reset (any state, including mid-MULT):
  - Next edge: state=IDLE, out_valid=0, result=0, zero=1, overflow=0, illegal=0, ALUOperation=1001, busy=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Any in-flight op is discarded and no stale out_valid follows.
- Simultaneous reset and in_valid: reset wins, request not accepted.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Decode sweep: every table selector, plus 111_101010 and 000_000000. ALUOperation equals the table code; the two illegal selectors give 1001, illegal=1, result=0.
- Single-cycle ops with handshake, DATA_WIDTH=32:
  - ADD 0x7FFFFFFF+1 gives 0x80000000, overflow=1.
  - SUB 5-5 gives 0, zero=1.
  - LUI b=0x1234 gives 0x12340000.
  - SLL b=1, shamt=31 gives 0x80000000.
  - Each has out_valid exactly 1 cycle after acceptance.
- MULT 0x0001_0003 * 0x0000_0005 gives 0x0005_000F. out_valid arrives 33 cycles after acceptance; in_ready=0 and busy=1 throughout.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Result, flags and out_valid stay stable, in_valid is ignored, and acceptance resumes the cycle after out_ready=1.
- Reset asserted on MULT iteration 12. Next cycle state=IDLE, out_valid=0, result=0, ALUOperation=1001; no out_valid appears for the aborted op. A following ADD 2+3 gives 5.
- Re-parametrise DATA_WIDTH=16, SHAMT_WIDTH=4:
  - LUI b=0x00AB gives 0xAB00.
  - MULT 0x00FF*0x0101 gives 0xFFFF after 17 cycles.
  - SRL 0x8000 by 15 gives 0x0001.
